fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RISC-V core: maintains the fetch PC, issues word reads to instruction memory over a request/grant/response interface, and buffers returned instructions in a small in-order queue. It presents {instruction, PC, fault} to the decode stage through a valid/ready handshake. Decode then extracts I/S/B/U/J/Z immediates from the instruction. It also accepts PC redirects from execute, discarding stale in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- DEPTH, 4: queue entries and maximum in-flight plus queued words; power of 2, ≥2.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- redirect_valid  in  1  redirect fetch this cycle.
- redirect_pc  in  32  redirect target; bits [1:0] forced to 0 internally.
- imem_req  out  1  read request.
- imem_addr  out  32  word-aligned read address (= fetch_pc).
- imem_gnt  in  1  request accepted this cycle; only meaningful with imem_req.
- imem_rvalid  in  1  response valid; in order, ≥1 cycle after its grant, ≤1 per cycle.
- imem_rdata  in  32  response instruction word.
- imem_err  in  1  access fault, qualified by imem_rvalid.
- if_valid  out  1  queue head valid.
- if_ready  in  1  decode accepts head.
- if_inst  out  32  head instruction.
- if_pc  out  32  head PC.
- if_fault  out  1  head fetched with imem_err.

## Operation
- State: fetch_pc, head_pc, queue (DEPTH × 33 bits: inst, fault), count, outstanding, discard.
- Credit: issue_ok = (count + outstanding + discard) < DEPTH, from registered values only. No combinational path from if_ready to imem_req.
- imem_req = issue_ok && !redirect_valid. On imem_req && imem_gnt: fetch_pc += 4 (wraps modulo 2^32), outstanding += 1.
- Response (imem_rvalid): if discard > 0, drop the response and decrement discard. Otherwise push {rdata, err} and decrement outstanding.
- Pop on if_valid && if_ready: head_pc += 4, count -= 1.
- Push and pop in the same cycle are both performed. Overflow is impossible by credit, and the credit check is a verification assertion.
- if_valid = (count != 0). The head outputs come from the queue; no bypass of imem_rdata.
- if_fault=1 entries still carry rdata as received. The fetch stream continues; trap handling is downstream.
- Redirect (highest priority):
  - fetch_pc and head_pc load {redirect_pc[31:2], 2'b00}.
  - count <= 0.
  - discard <= discard + outstanding − (imem_rvalid ? 1 : 0); outstanding <= 0.
  - A response arriving in the redirect cycle is always dropped.
  - A pop in the redirect cycle is ignored; decode must not rely on it.
- Reset: synchronous; all in-flight state is forgotten. Memory is reset by the same rst_n.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC while rst_n=0.
  - if_valid=0, if_inst=0, if_pc=RESET_PC, if_fault=0.
  - count=outstanding=discard=0.
- First imem_req=1 with imem_addr=RESET_PC occurs in the first cycle with rst_n=1.
- Latency: rvalid in cycle N gives if_valid=1 in cycle N+1. With grant in N and rvalid in N+1, if_valid is 1 in N+2.
- Throughput: one instruction per cycle when the memory grants each cycle with 1-cycle response and if_ready=1.
- Backpressure: with if_ready=0, at most DEPTH words are granted beyond the last pop, then imem_req drops. imem_req reasserts the cycle after the first pop.
- Redirect: imem_req=0 in the redirect cycle. The next cycle requests the redirect target, if credit allows given discard.
- if_* outputs hold stable while if_valid && !if_ready.

## Test plan
- Reset release, gnt=1: cycle 1 after release imem_req=1, addr=0x0. With 1-cycle rvalid, if_pc sequence is 0x0, 0x4, 0x8 on consecutive cycles, if_valid continuous from cycle 3.
- Backpressure, DEPTH=4, if_ready=0: exactly 4 grants (0x0–0xC), then imem_req=0 indefinitely. Raising if_ready yields if_inst in grant order, and a new request at 0x10 the cycle after the first pop.
- Redirect to 0x1002 with 2 responses outstanding: both responses dropped. Next if_pc=0x1000, with the inst returned for address 0x1000.
- Redirect in the same cycle as imem_rvalid with 1 outstanding: that response dropped, discard=0, if_valid=0 until the new-target response arrives.
- imem_err=1 on the response for 0x8: that entry shows if_fault=1, if_pc=0x8. Neighbouring entries show if_fault=0 and fetching continues.
- rst_n low mid-stream with 3 queued and 1 outstanding: next cycle if_valid=0, imem_req=0. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: RISC-V fetch stage with credit-limited imem request port, in-order instruction queue and redirect discard tracking
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        if_fault
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0] fetch_pc, head_pc, target;
  logic [32:0] queue [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, outstanding, discard;
  logic [CW+1:0] inflight;
  logic issue_ok, grant, push, pop;
  always_comb begin
    inflight = (CW+2)'(count) + (CW+2)'(outstanding) + (CW+2)'(discard);
    issue_ok = inflight < (CW+2)'(DEPTH);
    imem_req = rst_n && issue_ok && !redirect_valid;
    imem_addr = rst_n ? fetch_pc : RESET_PC;
    grant = imem_req && imem_gnt;
    push = imem_rvalid && discard == '0;
    if_valid = count != '0;
    pop = if_valid && if_ready;
    {if_inst, if_fault} = queue[rd_ptr];
    if_pc = head_pc;
    target = redirect_pc & 32'hFFFF_FFFC;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      head_pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      outstanding <= '0;
      discard <= '0;
      for (int i = 0; i < DEPTH; i++) queue[i] <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= target;
      head_pc <= target;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      outstanding <= '0;
      discard <= discard + outstanding - CW'(imem_rvalid);
    end else begin
      if (grant) fetch_pc <= fetch_pc + 32'd4;
      if (push) begin
        queue[wr_ptr] <= {imem_rdata, imem_err};
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        head_pc <= head_pc + 32'd4;
      end
      count <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(grant) - CW'(push);
      discard <= discard - CW'(imem_rvalid && !push);
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n) inflight <= (CW+2)'(DEPTH));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table vectors, directed corner sequences and random traffic checked against a queue-based fetch model
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n, redirect_valid, imem_req, imem_gnt, imem_rvalid, imem_err, if_valid, if_ready, if_fault;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, if_inst, if_pc;
  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .imem_err(imem_err), .if_valid(if_valid), .if_ready(if_ready),
    .if_inst(if_inst), .if_pc(if_pc), .if_fault(if_fault)
  );
  always #5 clk = ~clk;
  typedef struct { logic [31:0] a; int ep; } mem_ent_t;
  typedef struct {
    bit rs; logic rst; logic rdy; logic e_req; logic [31:0] e_addr;
    logic e_valid; logic [31:0] e_pc; logic [31:0] e_inst;
  } vec_t;
  mem_ent_t pend[$];
  logic [31:0] outq[$];
  vec_t tv[$];
  int epoch, checks, failures;
  logic [31:0] fpc;
  bit primed, err_en, rsp_en;
  logic s_req, s_valid, s_fault;
  logic [31:0] s_addr, s_pc, s_inst;
  function automatic logic [31:0] inst_of(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0013_5793;
  endfunction
  function automatic logic err_of(logic [31:0] a);
    return err_en && a[4:2] == 3'd2;
  endfunction
  function automatic vec_t mk(bit rs, logic rst, logic rdy, logic req, logic [31:0] addr,
                              logic v, logic [31:0] pc, logic [31:0] inst);
    vec_t r;
    r.rs = rs; r.rst = rst; r.rdy = rdy; r.e_req = req; r.e_addr = addr;
    r.e_valid = v; r.e_pc = pc; r.e_inst = inst;
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    mem_ent_t e;
    imem_rvalid = rsp_en && pend.size() > 0;
    imem_rdata = imem_rvalid ? inst_of(pend[0].a) : 32'h0;
    imem_err = imem_rvalid ? err_of(pend[0].a) : 1'b0;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = if_valid;
    s_pc = if_pc; s_inst = if_inst; s_fault = if_fault;
    chk("imem_req", s_req, rst_n && (outq.size() + pend.size() < DEPTH) && !redirect_valid);
    if (!rst_n || s_req) chk("imem_addr", s_addr, rst_n ? fpc : RESET_PC);
    if (primed) begin
      chk("if_valid", s_valid, outq.size() != 0);
      if (outq.size() > 0) begin
        chk("if_pc", s_pc, outq[0]);
        chk("if_inst", s_inst, inst_of(outq[0]));
        chk("if_fault", s_fault, err_of(outq[0]));
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      pend.delete(); outq.delete(); fpc = RESET_PC; primed = 1;
    end else if (redirect_valid) begin
      if (imem_rvalid) void'(pend.pop_front());
      outq.delete();
      fpc = redirect_pc & 32'hFFFF_FFFC;
      epoch++;
    end else begin
      if (s_valid && if_ready && outq.size() > 0) void'(outq.pop_front());
      if (imem_rvalid) begin
        e = pend.pop_front();
        if (e.ep == epoch) outq.push_back(e.a);
      end
      if (s_req && imem_gnt) begin
        e.a = fpc; e.ep = epoch;
        pend.push_back(e);
        fpc += 32'd4;
      end
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 0; redirect_valid = 0; imem_gnt = 0; if_ready = 0; rsp_en = 0;
    repeat (2) step();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    bit seen8;
    tv.push_back(mk(1, 0, 1, 0, 32'h0, 0, 32'h0, 32'h0));
    tv.push_back(mk(0, 1, 1, 1, 32'h0, 0, 32'h0, 32'h0));
    tv.push_back(mk(0, 1, 1, 1, 32'h4, 0, 32'h0, 32'h0));
    tv.push_back(mk(0, 1, 1, 1, 32'h8, 1, 32'h0, inst_of(32'h0)));
    tv.push_back(mk(0, 1, 1, 1, 32'hC, 1, 32'h4, inst_of(32'h4)));
    tv.push_back(mk(0, 1, 1, 1, 32'h10, 1, 32'h8, inst_of(32'h8)));
    tv.push_back(mk(1, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0));
    tv.push_back(mk(0, 1, 0, 1, 32'h0, 0, 32'h0, 32'h0));
    tv.push_back(mk(0, 1, 0, 1, 32'h4, 0, 32'h0, 32'h0));
    tv.push_back(mk(0, 1, 0, 1, 32'h8, 1, 32'h0, inst_of(32'h0)));
    tv.push_back(mk(0, 1, 0, 1, 32'hC, 1, 32'h0, inst_of(32'h0)));
    tv.push_back(mk(0, 1, 0, 0, 32'h0, 1, 32'h0, inst_of(32'h0)));
    tv.push_back(mk(0, 1, 0, 0, 32'h0, 1, 32'h0, inst_of(32'h0)));
    tv.push_back(mk(0, 1, 0, 0, 32'h0, 1, 32'h0, inst_of(32'h0)));
    tv.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'h0, inst_of(32'h0)));
    tv.push_back(mk(0, 1, 1, 1, 32'h10, 1, 32'h4, inst_of(32'h4)));
    tv.push_back(mk(0, 1, 1, 1, 32'h14, 1, 32'h8, inst_of(32'h8)));
    tv.push_back(mk(0, 1, 1, 1, 32'h18, 1, 32'hC, inst_of(32'hC)));
    tv.push_back(mk(0, 1, 1, 1, 32'h1C, 1, 32'h10, inst_of(32'h10)));
    checks = 0; failures = 0; epoch = 0; primed = 0; err_en = 0; rsp_en = 0;
    fpc = RESET_PC; rst_n = 0; redirect_valid = 0; redirect_pc = 0;
    imem_gnt = 0; if_ready = 0; imem_rvalid = 0; imem_rdata = 0; imem_err = 0;
    @(negedge clk);
    do_reset();
    foreach (tv[k]) begin
      if (tv[k].rs) do_reset();
      rst_n = tv[k].rst; if_ready = tv[k].rdy; imem_gnt = 1; rsp_en = 1; redirect_valid = 0;
      step();
      chk($sformatf("tv%0d_req", k), s_req, tv[k].e_req);
      if (tv[k].e_req) chk($sformatf("tv%0d_addr", k), s_addr, tv[k].e_addr);
      chk($sformatf("tv%0d_valid", k), s_valid, tv[k].e_valid);
      chk($sformatf("tv%0d_pc", k), s_pc, tv[k].e_pc);
      chk($sformatf("tv%0d_inst", k), s_inst, tv[k].e_inst);
    end
    do_reset();
    rst_n = 1; if_ready = 0; imem_gnt = 1; rsp_en = 0;
    repeat (2) step();
    redirect_valid = 1; redirect_pc = 32'h1002;
    step();
    chk("redir2_req", s_req, 0);
    redirect_valid = 0;
    step();
    chk("redir2_tgt_req", s_req, 1);
    chk("redir2_tgt_addr", s_addr, 32'h1000);
    imem_gnt = 0; rsp_en = 1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (s_valid) break;
    end
    chk("redir2_wait", s_valid, 1);
    chk("redir2_pc", s_pc, 32'h1000);
    chk("redir2_inst", s_inst, inst_of(32'h1000));
    do_reset();
    rst_n = 1; if_ready = 1; imem_gnt = 1; rsp_en = 0;
    step();
    imem_gnt = 0; rsp_en = 1; redirect_valid = 1; redirect_pc = 32'h200;
    step();
    chk("redir1_req", s_req, 0);
    redirect_valid = 0; imem_gnt = 1;
    step();
    chk("redir1_tgt_req", s_req, 1);
    chk("redir1_tgt_addr", s_addr, 32'h200);
    chk("redir1_empty0", s_valid, 0);
    imem_gnt = 0;
    step();
    chk("redir1_empty1", s_valid, 0);
    step();
    chk("redir1_valid", s_valid, 1);
    chk("redir1_pc", s_pc, 32'h200);
    chk("redir1_inst", s_inst, inst_of(32'h200));
    do_reset();
    err_en = 1;
    rst_n = 1; if_ready = 1; imem_gnt = 1; rsp_en = 1; seen8 = 0;
    repeat (8) begin
      step();
      if (s_valid) begin
        chk("err_fault", s_fault, s_pc == 32'h8);
        if (s_pc == 32'h8) seen8 = 1;
      end
    end
    chk("err_seen8", seen8, 1);
    do_reset();
    rst_n = 1; if_ready = 0; imem_gnt = 1; rsp_en = 1;
    repeat (4) step();
    rst_n = 0;
    step();
    chk("rstmid_req", s_req, 0);
    chk("rstmid_held", s_valid, 1);
    step();
    chk("rstmid_valid", s_valid, 0);
    chk("rstmid_req2", s_req, 0);
    rst_n = 1;
    step();
    chk("rstmid_restart_req", s_req, 1);
    chk("rstmid_restart_addr", s_addr, RESET_PC);
    for (int n = 0; n < 3000; n++) begin
      rst_n = $urandom_range(299) != 0;
      imem_gnt = $urandom_range(3) != 0;
      rsp_en = $urandom_range(9) < 7;
      if_ready = $urandom_range(9) < 6;
      redirect_valid = $urandom_range(24) == 0;
      redirect_pc = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
